// File: rtl/game_state_ctrl.sv
// EatUp game sequencer: debounced start/pause buttons, MENU/RUN/PAUSE/OVER/WIN FSM and round timer.
// Optional best-time tracking is built when HISCORE_EN is defined.
module game_state_ctrl #(
  parameter int unsigned TICK_CYCLES     = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned GAME_SECONDS    = 60,
  parameter int unsigned R_MIN           = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [5:0] r,
  output logic       gamemenu,
  output logic       gamerun,
  output logic       gamepause,
  output logic       game_over,
  output logic       game_win,
  output logic [7:0] time_left,
  output logic [7:0] best_time
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    SECONDS   = 8'(GAME_SECONDS);

  typedef enum logic [2:0] {S_MENU, S_RUN, S_PAUSE, S_OVER, S_WIN} state_t;

  function automatic logic [4:0] flags_of(input state_t s);
    return {s == S_MENU, s == S_RUN, s == S_PAUSE, s == S_OVER, s == S_WIN};
  endfunction

  // Bit 0 is start, bit 1 is pause.
  logic [1:0]    btn_raw, sync1, sync2, deb, press;
  logic [DW-1:0] stable_cnt [2];

  assign btn_raw = {btn_pause, btn_start};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 2; i++) stable_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= '0;
      // Counter only runs while the synchronized level disagrees with the accepted one.
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == DEB_MAX) begin
          stable_cnt[i] <= '0;
          deb[i]        <= sync2[i];
          press[i]      <= sync2[i];
        end else begin
          stable_cnt[i] <= stable_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic          start_p, pause_p;
  state_t        state;
  logic [4:0]    flags_q;
  logic [7:0]    time_q, time_nx;
  logic [PW-1:0] presc;
  logic          armed, tick, lose, win;

  assign start_p = press[0];
  assign pause_p = press[1];
  assign tick    = (state == S_RUN) && (presc == PRESC_MAX);
  assign lose    = (state == S_RUN) && armed && (32'(r) <= R_MIN);
  assign win     = tick && (time_q == 8'd1);
  assign time_nx = (tick && time_q != '0) ? time_q - 8'd1 : time_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_MENU;
      flags_q <= flags_of(S_MENU);
      time_q  <= SECONDS;
      presc   <= '0;
      armed   <= 1'b0;
    end else begin
      case (state)
        S_MENU: begin
          if (start_p) begin
            state   <= S_RUN;
            flags_q <= flags_of(S_RUN);
            time_q  <= SECONDS;
            presc   <= '0;
            armed   <= 1'b0;
          end
        end
        S_RUN: begin
          presc  <= tick ? '0 : presc + 1'b1;
          time_q <= time_nx;
          if (tick) armed <= 1'b1;
          if (lose) begin
            state   <= S_OVER;
            flags_q <= flags_of(S_OVER);
          end else if (win) begin
            state   <= S_WIN;
            flags_q <= flags_of(S_WIN);
          end else if (pause_p) begin
            state   <= S_PAUSE;
            flags_q <= flags_of(S_PAUSE);
          end
        end
        S_PAUSE: begin
          if (start_p) begin
            state   <= S_MENU;
            flags_q <= flags_of(S_MENU);
          end else if (pause_p) begin
            state   <= S_RUN;
            flags_q <= flags_of(S_RUN);
          end
        end
        S_OVER, S_WIN: begin
          if (start_p) begin
            state   <= S_MENU;
            flags_q <= flags_of(S_MENU);
          end
        end
        default: begin
          state   <= S_MENU;
          flags_q <= flags_of(S_MENU);
        end
      endcase
    end
  end

  assign {gamemenu, gamerun, gamepause, game_over, game_win} = flags_q;
  assign time_left = time_q;

`ifdef HISCORE_EN
  logic [7:0] best_q, survived;

  // Uses the post-tick time so a loss on a tick edge counts that second as survived.
  assign survived = SECONDS - time_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
    end else if ((lose || win) && survived > best_q) begin
      best_q <= survived;
    end
  end

  assign best_time = best_q;
`else
  assign best_time = '0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl with small timing parameters and randomized radius/timing.
// Expected values come from arithmetic on elapsed run time and button latency.
module tb_game_state_ctrl;
  localparam int unsigned TICK = 10;
  localparam int unsigned DEB  = 4;
  localparam int unsigned GS   = 5;
  localparam int unsigned RMIN = 10;
  localparam int unsigned LAT  = 2 + DEB + 1;

  localparam logic [4:0] F_MENU  = 5'b10000;
  localparam logic [4:0] F_RUN   = 5'b01000;
  localparam logic [4:0] F_PAUSE = 5'b00100;
  localparam logic [4:0] F_OVER  = 5'b00010;
  localparam logic [4:0] F_WIN   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [5:0] r = 6'd20;
  logic       gamemenu, gamerun, gamepause, game_over, game_win;
  logic [7:0] time_left, best_time;
  logic [4:0] flags;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned best_m  = 0;

  game_state_ctrl #(
    .TICK_CYCLES(TICK),
    .DEBOUNCE_CYCLES(DEB),
    .GAME_SECONDS(GS),
    .R_MIN(RMIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause), .r(r),
    .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
    .game_over(game_over), .game_win(game_win), .time_left(time_left), .best_time(best_time)
  );

  assign flags = {gamemenu, gamerun, gamepause, game_over, game_win};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [5:0] r_safe();
    return 6'($urandom_range(63, RMIN + 1));
  endfunction

  function automatic logic [5:0] r_low();
    return 6'($urandom_range(RMIN, 0));
  endfunction

  // Best time only exists in the model when the feature is built.
  function automatic void note_survived(input int unsigned s);
`ifdef HISCORE_EN
    if (s > best_m) best_m = s;
`endif
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int unsigned n, input bit low);
    for (int unsigned i = 0; i < n; i++) begin
      r = low ? r_low() : r_safe();
      step(1);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    best_m = 0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic start_round();
    btn_start = 1'b1;
    step(LAT);
    btn_start = 1'b0;
    n_total++;
    if (flags !== F_RUN || time_left !== 8'(GS))
      $display("FAIL round_start flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_RUN, GS);
    else n_pass++;
  endtask

  task automatic test_reset();
    r = 6'd20;
    do_reset();
    n_total++;
    if (flags !== F_MENU) $display("FAIL reset_flags got=%b exp=%b", flags, F_MENU);
    else n_pass++;
    n_total++;
    if (time_left !== 8'(GS)) $display("FAIL reset_time got=%0d exp=%0d", time_left, GS);
    else n_pass++;
    n_total++;
    if (best_time !== 8'd0) $display("FAIL reset_best got=%0d exp=0", best_time);
    else n_pass++;
  endtask

  task automatic test_start_latency();
    do_reset();
    btn_start = 1'b1;
    for (int unsigned k = 1; k < LAT; k++) begin
      step(1);
      n_total++;
      if (flags !== F_MENU) $display("FAIL start_early cycle=%0d got=%b exp=%b", k, flags, F_MENU);
      else n_pass++;
    end
    step(1);
    n_total++;
    if (flags !== F_RUN || time_left !== 8'(GS))
      $display("FAIL start_latency flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_RUN, GS);
    else n_pass++;
    // Start held through the first tick must not leave RUN.
    run_cycles(20 - LAT, 0);
    n_total++;
    if (flags !== F_RUN || time_left !== 8'(GS - 1))
      $display("FAIL start_ignored flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_RUN, GS - 1);
    else n_pass++;
    btn_start = 1'b0;
  endtask

  task automatic test_bounce();
    do_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      btn_start = ~btn_start;
      step(2);
      n_total++;
      if (flags !== F_MENU) $display("FAIL bounce iter=%0d got=%b exp=%b", i, flags, F_MENU);
      else n_pass++;
    end
    btn_start = 1'b0;
    step(10);
    n_total++;
    if (flags !== F_MENU) $display("FAIL bounce_settle got=%b exp=%b", flags, F_MENU);
    else n_pass++;
  endtask

  task automatic test_win();
    do_reset();
    r = r_safe();
    start_round();
    for (int unsigned sec = 1; sec <= GS; sec++) begin
      run_cycles(TICK - 1, 0);
      n_total++;
      if (flags !== F_RUN || time_left !== 8'(GS - sec + 1))
        $display("FAIL win_pre sec=%0d flags=%b time=%0d exp time=%0d", sec, flags, time_left, GS - sec + 1);
      else n_pass++;
      run_cycles(1, 0);
      n_total++;
      if (sec < GS) begin
        if (flags !== F_RUN || time_left !== 8'(GS - sec))
          $display("FAIL win_tick sec=%0d flags=%b time=%0d exp time=%0d", sec, flags, time_left, GS - sec);
        else n_pass++;
      end else begin
        if (flags !== F_WIN || time_left !== 8'd0)
          $display("FAIL win_end flags=%b time=%0d exp flags=%b time=0", flags, time_left, F_WIN);
        else n_pass++;
      end
    end
    note_survived(GS);
    n_total++;
    if (best_time !== 8'(best_m)) $display("FAIL win_best got=%0d exp=%0d", best_time, best_m);
    else n_pass++;
    btn_pause = 1'b1;
    run_cycles(LAT + 1, 0);
    btn_pause = 1'b0;
    n_total++;
    if (flags !== F_WIN || time_left !== 8'd0)
      $display("FAIL win_pause_ignored flags=%b time=%0d exp flags=%b", flags, time_left, F_WIN);
    else n_pass++;
    step(8);
    btn_start = 1'b1;
    step(LAT);
    btn_start = 1'b0;
    n_total++;
    if (flags !== F_MENU || time_left !== 8'd0)
      $display("FAIL win_to_menu flags=%b time=%0d exp flags=%b time=0", flags, time_left, F_MENU);
    else n_pass++;
    step(8);
  endtask

  task automatic test_loss_first_tick();
    do_reset();
    r = r_low();
    start_round();
    run_cycles(TICK - 1, 1);
    n_total++;
    if (flags !== F_RUN || time_left !== 8'(GS))
      $display("FAIL loss_unarmed flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_RUN, GS);
    else n_pass++;
    run_cycles(1, 1);
    n_total++;
    if (flags !== F_RUN || time_left !== 8'(GS - 1))
      $display("FAIL loss_tick flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_RUN, GS - 1);
    else n_pass++;
    run_cycles(1, 1);
    note_survived(1);
    n_total++;
    if (flags !== F_OVER || time_left !== 8'(GS - 1) || best_time !== 8'(best_m))
      $display("FAIL loss_over flags=%b time=%0d best=%0d exp flags=%b time=%0d best=%0d",
               flags, time_left, best_time, F_OVER, GS - 1, best_m);
    else n_pass++;
  endtask

  task automatic test_loss_random();
    do_reset();
    for (int unsigned round = 0; round < 4; round++) begin
      int unsigned m, j;
      m = $urandom_range(3, 1);
      j = $urandom_range(TICK - 2, 0);
      r = r_safe();
      start_round();
      run_cycles(TICK * m + j, 0);
      n_total++;
      if (flags !== F_RUN || time_left !== 8'(GS - m))
        $display("FAIL lossr_pre round=%0d flags=%b time=%0d exp time=%0d", round, flags, time_left, GS - m);
      else n_pass++;
      r = r_low();
      step(1);
      note_survived(m);
      n_total++;
      if (flags !== F_OVER || time_left !== 8'(GS - m) || best_time !== 8'(best_m))
        $display("FAIL lossr_over round=%0d flags=%b time=%0d best=%0d exp time=%0d best=%0d",
                 round, flags, time_left, best_time, GS - m, best_m);
      else n_pass++;
      btn_start = 1'b1;
      step(LAT);
      btn_start = 1'b0;
      n_total++;
      if (flags !== F_MENU || best_time !== 8'(best_m))
        $display("FAIL lossr_menu round=%0d flags=%b best=%0d exp best=%0d", round, flags, best_time, best_m);
      else n_pass++;
      step(8);
    end
  endtask

  task automatic test_pause();
    int unsigned j, frozen;
    do_reset();
    r = r_safe();
    start_round();
    j = $urandom_range(2, 0);
    run_cycles(2 * TICK + j, 0);
    btn_pause = 1'b1;
    run_cycles(LAT, 0);
    btn_pause = 1'b0;
    frozen = LAT + j;
    n_total++;
    if (flags !== F_PAUSE || time_left !== 8'(GS - 2))
      $display("FAIL pause_enter flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_PAUSE, GS - 2);
    else n_pass++;
    run_cycles(100, 0);
    n_total++;
    if (flags !== F_PAUSE || time_left !== 8'(GS - 2))
      $display("FAIL pause_hold flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_PAUSE, GS - 2);
    else n_pass++;
    btn_pause = 1'b1;
    run_cycles(LAT, 0);
    btn_pause = 1'b0;
    n_total++;
    if (flags !== F_RUN) $display("FAIL pause_resume got=%b exp=%b", flags, F_RUN);
    else n_pass++;
    // Next tick lands after the remaining (TICK - frozen) prescaler counts.
    run_cycles(TICK - frozen - 1, 0);
    n_total++;
    if (time_left !== 8'(GS - 2)) $display("FAIL resume_pre got=%0d exp=%0d", time_left, GS - 2);
    else n_pass++;
    run_cycles(1, 0);
    n_total++;
    if (flags !== F_RUN || time_left !== 8'(GS - 3))
      $display("FAIL resume_tick flags=%b time=%0d exp time=%0d", flags, time_left, GS - 3);
    else n_pass++;
  endtask

  task automatic test_pause_abandon();
    do_reset();
    r = r_safe();
    start_round();
    run_cycles(1, 0);
    btn_pause = 1'b1;
    run_cycles(LAT, 0);
    btn_pause = 1'b0;
    n_total++;
    if (flags !== F_PAUSE) $display("FAIL abandon_pause got=%b exp=%b", flags, F_PAUSE);
    else n_pass++;
    step(8);
    btn_start = 1'b1;
    btn_pause = 1'b1;
    step(LAT);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    n_total++;
    if (flags !== F_MENU || time_left !== 8'(GS))
      $display("FAIL abandon_menu flags=%b time=%0d exp flags=%b time=%0d", flags, time_left, F_MENU, GS);
    else n_pass++;
    step(8);
  endtask

  task automatic test_async_reset();
    do_reset();
    r = r_low();
    start_round();
    run_cycles(TICK + 1, 1);
    note_survived(1);
    n_total++;
    if (flags !== F_OVER || best_time !== 8'(best_m))
      $display("FAIL areset_setup flags=%b best=%0d exp flags=%b best=%0d", flags, best_time, F_OVER, best_m);
    else n_pass++;
    btn_start = 1'b1;
    step(LAT);
    btn_start = 1'b0;
    step(8);
    r = r_safe();
    start_round();
    run_cycles(15, 0);
    #2;
    rst_n = 1'b0;
    #1;
    best_m = 0;
    n_total++;
    if (flags !== F_MENU || time_left !== 8'(GS) || best_time !== 8'd0)
      $display("FAIL async_reset flags=%b time=%0d best=%0d exp flags=%b time=%0d best=0",
               flags, time_left, best_time, F_MENU, GS);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    step(3);
    n_total++;
    if (flags !== F_MENU) $display("FAIL areset_after got=%b exp=%b", flags, F_MENU);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_bounce();
    test_win();
    test_loss_first_tick();
    test_loss_random();
    test_pause();
    test_pause_abandon();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
Top-level game sequencer for EatUp. It debounces the start and pause buttons and runs the MENU/RUN/PAUSE/OVER/WIN state machine. It drives the one-hot gamemenu/gamerun/gamepause controls consumed by the radius stage. It watches the radius value r coming back from that stage and ends the round when the player shrinks to the minimum or survives the round timer.

Parameters:
TICK_CYCLES, 100000000, clk cycles per game-second tick (1 s at 100 MHz)
DEBOUNCE_CYCLES, 1000000, cycles a synchronized button must be stable before it is accepted (10 ms)
GAME_SECONDS, 60, round length in seconds, legal range 1..255
R_MIN, 10, radius at or below which the round is lost

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_start  in  1  raw start/return button, asynchronous, active-high
btn_pause  in  1  raw pause/resume button, asynchronous, active-high
r  in  6  current player radius from the radius stage
gamemenu  out  1  high in MENU
gamerun  out  1  high in RUN
gamepause  out  1  high in PAUSE
game_over  out  1  high in OVER
game_win  out  1  high in WIN
time_left  out  8  seconds remaining in the round
best_time  out  8  best survived seconds (HISCORE_EN only, else constant 0)

Behaviour:
- Reset (rst_n low, async) values:
  - state = MENU; gamemenu = 1; all other flags 0.
  - time_left = GAME_SECONDS; best_time = 0.
  - Prescaler 0; armed 0; debouncers cleared to "released".
- Button path, per button:
  - 2-FF synchronizer, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - A 1-cycle press pulse fires on the debounced 0->1 edge. Release produces no pulse.
  - Latency from a stable raw press to the pulse is 2 + DEBOUNCE_CYCLES cycles.
  - A bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- Tick prescaler:
  - Counts only in RUN. Holds its value in PAUSE. Cleared on the MENU->RUN transition.
  - When it reaches TICK_CYCLES-1: wraps to 0 and asserts tick for 1 cycle.
- State transitions (evaluated on posedge clk, one transition per cycle):
  - MENU: start pulse -> RUN. On this transition: time_left = GAME_SECONDS, prescaler = 0, armed = 0.
  - RUN, priority high to low:
    1. armed && r <= R_MIN -> OVER.
    2. tick && time_left == 1 -> WIN, time_left = 0.
    3. pause pulse -> PAUSE.
  - RUN: any tick decrements time_left and sets armed = 1.
  - RUN: a start pulse is ignored.
  - PAUSE: start pulse -> MENU (round abandoned), taking priority over pause; else pause pulse -> RUN.
  - PAUSE: time_left, prescaler and armed are all frozen.
  - OVER, WIN: start pulse -> MENU. Pause is ignored. time_left holds its final value.
- Purpose of armed:
  - After a new round starts, the radius stage restores r to 20 only on its own slow clock.
  - Loss detection is therefore suppressed until the first tick of the round.
  - armed survives PAUSE/resume.
- Outputs:
  - All flags are registered and decoded from the state, so at most one flag is high.
  - Flags update 1 cycle after the triggering pulse or tick.
- Arithmetic:
  - time_left is 8-bit unsigned and never decrements below 0.
  - r is compared as 6-bit unsigned.

Optional Feature:
HISCORE_EN
- Defined:
  - On entry to OVER or WIN, compute survived = GAME_SECONDS - time_left (8-bit).
  - If survived > best_time, best_time takes that value, registered in the same transition cycle.
  - best_time is cleared only by rst_n. Returning to MENU does not clear it.
- Undefined: best_time is tied to 0 and no extra registers are built.

Test Plan:
Bench parameters: TICK_CYCLES=10, DEBOUNCE_CYCLES=4, GAME_SECONDS=5, R_MIN=10.
1. Reset then release, r=20 -> gamemenu=1, time_left=5, other flags 0; btn_start high for 20 cycles -> gamerun=1 exactly 2+4+1 cycles after the press is applied, time_left=5.
2. btn_start toggled every 2 cycles for 20 cycles in MENU -> no transition, gamemenu stays 1.
3. RUN with r=20 for 50 cycles -> time_left steps 5,4,3,2,1 every 10 cycles; at the 5th tick game_win=1 and time_left=0; later start press -> gamemenu=1.
4. r=8 at RUN entry -> no loss before the first tick; at the first tick time_left=4, and on the next cycle game_over=1; with HISCORE_EN, best_time=1.
5. In RUN at time_left=3, press pause -> gamepause=1; hold 100 cycles -> time_left stays 3; press pause again -> gamerun=1 and the prescaler resumes from its frozen count.
6. Assert rst_n low mid-RUN for 1 cycle (async, no clock edge) -> gamemenu=1, time_left=5 immediately; best_time=0.
